// File: rtl/enc83_seq.sv
// Sequential 8-to-3 encoder: captures a request vector on load and emits the index
// of every set bit, one per handshake, in priority order, then pulses done.
module enc83_seq #(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       none
);

    localparam int unsigned VEC_W = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   pend_q, pend_d;
    logic               none_q, none_d;
    logic [IDX_W-1:0]   idx;
    logic [VEC_W-1:0]   idx_mask;

    // Priority encode of the pending bits; the winning end depends on HIGH_FIRST.
    always_comb begin
        idx = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < int'(VEC_W); i++) begin
                if (pend_q[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
                if (pend_q[i]) idx = IDX_W'(i);
            end
        end
    end

    assign idx_mask = VEC_W'(1) << idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
        end
    end

    // Next-state logic; nothing advances while en is low.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        pend_d  = in;
                        none_d  = (in == '0);
                        state_d = (in == '0) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        pend_d = pend_q & ~idx_mask;
                        if ((pend_q & ~idx_mask) == '0) state_d = DONE;
                    end
                end
                DONE: begin
                    none_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    pend_d  = '0;
                    none_d  = 1'b0;
                end
            endcase
        end
    end

    // Handshake and status outputs decode the registered state; en gates the pulses.
    always_comb begin
        out       = idx;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        none      = 1'b0;
        if (state_q != IDLE) busy = 1'b1;
        if (en && state_q == SCAN) out_valid = 1'b1;
        if (en && state_q == DONE) begin
            done = 1'b1;
            none = none_q;
        end
    end

endmodule
